// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a valid/ready handshake on both sides.
// An output register plus one skid entry keep in_ready fully registered.
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] CTL_ADD = 3'b000;
  localparam logic [2:0] CTL_SUB = 3'b001;
  localparam logic [2:0] CTL_AND = 3'b010;
  localparam logic [2:0] CTL_OR  = 3'b011;
  localparam logic [2:0] CTL_SLT = 3'b101;
  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic entry_t alu_eval(
    input logic [2:0]       ctl,
    input logic [XLEN-1:0]  a,
    input logic [XLEN-1:0]  b,
    input logic [TAG_W-1:0] tag
  );
    entry_t                 e;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0]        sum;
    logic [XLEN-1:0]        diff;
    sa   = $signed(a);
    sb   = $signed(b);
    sum  = a + b;
    diff = a + ~b + ONE;
    e     = '0;
    e.tag = tag;
    case (ctl)
      CTL_ADD: begin
        e.result   = sum;
        e.overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      CTL_SUB: begin
        e.result   = diff;
        e.overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      CTL_AND: e.result = a & b;
      CTL_OR:  e.result = a | b;
      CTL_SLT: e.result = (sa < sb) ? ONE : '0;
      default: e.illegal = 1'b1;
    endcase
    // Illegal codes leave result at 0, so zero reads 1 for them too.
    e.zero = (e.result == '0);
    return e;
  endfunction

  entry_t or_q, or_d;
  entry_t sk_q, sk_d;
  entry_t new_entry;
  logic   or_vld_q, or_vld_d;
  logic   sk_vld_q, sk_vld_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   consume;

  assign new_entry = alu_eval(alu_control, src_a, src_b, in_tag);
  assign accept    = in_valid && in_ready_q;
  assign consume   = or_vld_q && out_ready;

  always_comb begin
    or_d     = or_q;
    sk_d     = sk_q;
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    if (flush) begin
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end else if (consume && sk_vld_q) begin
      // in_ready is low whenever SK is full, so no accept can coincide here.
      or_d     = sk_q;
      sk_vld_d = 1'b0;
    end else if (accept) begin
      if (!or_vld_q || consume) begin
        or_d     = new_entry;
        or_vld_d = 1'b1;
      end else begin
        sk_d     = new_entry;
        sk_vld_d = 1'b1;
      end
    end else if (consume) begin
      or_vld_d = 1'b0;
    end
    in_ready_d = ~sk_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q       <= '0;
      sk_q       <= '0;
      or_vld_q   <= 1'b0;
      sk_vld_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_vld_q   <= or_vld_d;
      sk_vld_q   <= sk_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_vld_q;
  assign result    = or_q.result;
  assign zero      = or_q.zero;
  assign overflow  = or_q.overflow;
  assign illegal   = or_q.illegal;
  assign out_tag   = or_q.tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU functions, flags, backpressure,
// flush and asynchronous reset, checked with immediate assertions.
module tb_alu_exec_stage;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [XLEN-1:0]  src_a;
  logic [XLEN-1:0]  src_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  int checks   = 0;
  int failures = 0;

  alu_exec_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
    .src_a(src_a), .src_b(src_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction for a single edge, then drop in_valid.
  task automatic send(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tg);
    alu_control = ctl;
    src_a       = a;
    src_b       = b;
    in_tag      = tg;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] res, input logic z,
                            input logic ov, input logic il, input logic [4:0] tg);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_result"}, result, res);
    chk({nm, "_zero"}, 32'(zero), 32'(z));
    chk({nm, "_ovf"}, 32'(overflow), 32'(ov));
    chk({nm, "_illegal"}, 32'(illegal), 32'(il));
    chk({nm, "_tag"}, 32'(out_tag), 32'(tg));
  endtask

  initial begin
    int next_tag;
    int exp_tag;
    logic acc;
    logic cons;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = 3'b000; src_a = '0; src_b = '0; in_tag = '0;
    #13;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    step();

    // ALU functions with out_ready held high
    send(3'b000, 32'h0000_0005, 32'h0000_0003, 5'd1);
    expect_out("add", 32'h8, 1'b0, 1'b0, 1'b0, 5'd1);
    send(3'b001, 32'h8000_0000, 32'h0000_0001, 5'd2);
    expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd2);
    send(3'b001, 32'h0000_1234, 32'h0000_1234, 5'd3);
    expect_out("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0, 5'd3);
    send(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4);
    expect_out("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0, 5'd4);
    send(3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 5'd5);
    expect_out("slt_swap", 32'h0, 1'b1, 1'b0, 1'b0, 5'd5);
    send(3'b110, 32'h1234_5678, 32'h1111_1111, 5'd6);
    expect_out("ill_110", 32'h0, 1'b1, 1'b0, 1'b1, 5'd6);
    send(3'b100, 32'h0000_0001, 32'h0000_0001, 5'd7);
    expect_out("ill_100", 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
    send(3'b111, 32'h0000_0001, 32'h0000_0001, 5'd8);
    expect_out("ill_111", 32'h0, 1'b1, 1'b0, 1'b1, 5'd8);
    send(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd9);
    expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd9);
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10);
    expect_out("add_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 5'd10);
    send(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 5'd11);
    expect_out("and", 32'h0000_F000, 1'b0, 1'b0, 1'b0, 5'd11);
    send(3'b011, 32'h0000_F0F0, 32'h0000_0F00, 5'd12);
    expect_out("or", 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 5'd12);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: tag1 lands in OR, tag2 in SK, then in_ready drops
    alu_control = 3'b000; src_b = '0;
    src_a = 32'd1; in_tag = 5'd1; in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    src_a = 32'd2; in_tag = 5'd2;
    step();
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    src_a = 32'd3; in_tag = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_tag", 32'(out_tag), 32'd1);
      chk("bp_hold_result", result, 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    next_tag = 3;
    exp_tag  = 1;
    for (int cyc = 0; cyc < 40 && exp_tag <= 6; cyc++) begin
      in_valid = (next_tag <= 6);
      in_tag   = 5'(next_tag);
      src_a    = 32'(next_tag);
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        chk("bp_order_tag", 32'(out_tag), 32'(exp_tag));
        chk("bp_order_result", result, 32'(exp_tag));
        exp_tag++;
      end
      step();
      if (acc) next_tag++;
    end
    in_valid = 1'b0;
    chk("bp_all_received", 32'(exp_tag), 32'd7);
    step();
    chk("bp_empty_after", 32'(out_valid), 32'd0);

    // Flush with OR and SK full and a pending input
    out_ready = 1'b0;
    send(3'b000, 32'd10, 32'd0, 5'd10);
    send(3'b000, 32'd11, 32'd0, 5'd11);
    chk("fl_sk_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_tag = 5'd12; src_a = 32'd12; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_nothing_emerges", 32'(out_valid), 32'd0);
    end
    // Flush coincident with an accept into an empty stage
    in_valid = 1'b1; in_tag = 5'd13; src_a = 32'd13; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_accept_dropped", 32'(out_valid), 32'd0);
    step();
    chk("fl_accept_dropped2", 32'(out_valid), 32'd0);

    // Asynchronous reset with both entries held
    out_ready = 1'b0;
    send(3'b000, 32'd20, 32'd0, 5'd20);
    send(3'b000, 32'd21, 32'd0, 5'd21);
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_result", result, 32'd0);
    chk("ar_tag", 32'(out_tag), 32'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ar_idle", 32'(out_valid), 32'd0);
    send(3'b000, 32'h0000_0005, 32'h0000_0003, 5'd22);
    expect_out("ar_resume", 32'h8, 1'b0, 1'b0, 1'b0, 5'd22);
    send(3'b001, 32'h0000_0003, 32'h0000_0005, 5'd23);
    expect_out("ar_resume_sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 5'd23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
